// File: rtl/signmag_accumulator_if.sv
// Stream interface of the sign-magnitude accumulator: an input word stream
// (in_*) and a result port (out_*).
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are 1. A producer holding valid=1 keeps its data stable until the
// transfer. Ready may depend combinationally on the receiver's state, never
// on valid, so there is no combinational loop through the handshake.
interface signmag_accumulator_if #(
    parameter int N     = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
);
    // Input word stream
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;

    // Packet result port
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_ovf
    );

    // Accumulator side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_ovf
    );
endinterface

// File: rtl/signmag_accumulator.sv
// Sign-magnitude packet accumulator.
// Sums every packet of N-bit sign-magnitude words (ended by in_last) into an
// ACC_W-bit sign-magnitude accumulator with saturation and a sticky overflow
// flag, then offers one result per packet on the out_* port. -0 is never
// produced: any zero magnitude carries sign 0.
module signmag_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signmag_accumulator_if.slave  bus,
    output logic [1:0]            state_o    // FSM state for observation
);

    // Magnitude width of the accumulator and its saturation limits
    localparam int               MAG_W   = ACC_W - 1;
    localparam int               PAD_W   = MAG_W - (N - 1);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first word of a packet
        ACCUM = 2'd1,   // inside a packet, summing words
        HOLD  = 2'd2    // presenting the packet result
    } state_t;

    state_t           state_q, state_d;

    // Running packet state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Result registers: keep their value after the result is taken, until
    // the next packet completes.
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    // Handshake helpers
    logic             in_ready_w;
    logic             accept;

    // Normalised operand
    logic [MAG_W-1:0] in_mag;
    logic             in_sign;

    // Adder operands and result
    logic             base_sign;
    logic [MAG_W-1:0] base_mag;
    logic [MAG_W:0]   mag_sum;
    logic             sum_sign;
    logic [MAG_W-1:0] sum_mag;
    logic             sum_sat;

    assign accept  = bus.in_valid && in_ready_w;
    assign state_o = state_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && bus.in_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; in_ready is also held low while reset is asserted
    always_comb begin
        in_ready_w    = rst_n && (state_q != HOLD);
        bus.in_ready  = in_ready_w;
        bus.out_valid = (state_q == HOLD);
        bus.out_data  = out_data_q;
        bus.out_count = out_count_q;
        bus.out_ovf   = out_ovf_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Operand normalisation: zero-extend magnitude, fold -0 into +0
    always_comb begin
        in_mag  = {{PAD_W{1'b0}}, bus.in_data[N-2:0]};
        in_sign = bus.in_data[N-1] && (in_mag != '0);
    end

    // Sign-magnitude add of the operand to the running value. The first word
    // of a packet is added to +0, which yields the normalised operand itself.
    always_comb begin
        if (state_q == IDLE) begin
            base_sign = 1'b0;
            base_mag  = '0;
        end else begin
            base_sign = acc_q[ACC_W-1];
            base_mag  = acc_q[MAG_W-1:0];
        end

        mag_sum  = {1'b0, base_mag} + {1'b0, in_mag};
        sum_sign = base_sign;
        sum_mag  = base_mag;
        sum_sat  = 1'b0;

        if (base_sign == in_sign) begin
            // Same sign: magnitudes add, clamp at the largest magnitude
            if (mag_sum > {1'b0, MAG_MAX}) begin
                sum_mag = MAG_MAX;
                sum_sat = 1'b1;
            end else begin
                sum_mag = mag_sum[MAG_W-1:0];
            end
            sum_sign = base_sign;
        end else if (base_mag >= in_mag) begin
            // Opposite signs, running value dominates
            sum_mag  = base_mag - in_mag;
            sum_sign = base_sign;
        end else begin
            // Opposite signs, operand dominates
            sum_mag  = in_mag - base_mag;
            sum_sign = in_sign;
        end

        // Zero is always +0
        if (sum_mag == '0) begin
            sum_sign = 1'b0;
        end
    end

    // Next values of the running packet state and the result registers
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            acc_d = {sum_sign, sum_mag};
            if (state_q == IDLE) begin
                // First word starts a fresh packet
                cnt_d = CNT_ONE;
                ovf_d = 1'b0;
            end else begin
                // Count saturates rather than wrapping on very long packets
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                ovf_d = ovf_q | sum_sat;
            end

            // Capture the packet result together with the final word
            if (bus.in_last) begin
                out_data_d  = acc_d;
                out_count_d = cnt_d;
                out_ovf_d   = ovf_d;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: doc/signmag_accumulator.md
Name: signmag_accumulator

Overview:
Sequential accumulator that consumes the stream of N-bit sign-magnitude words produced by the signed-magnitude adder stage. It sums each packet of words, delimited by in_last, into a wider sign-magnitude register, with saturation and a sticky overflow flag. It then presents one result per packet on a valid/ready output port. It is the downstream stage of the adder in the sign-magnitude arithmetic datapath.

Parameters:
N, 4, input word width: bit N-1 is the sign, bits N-2:0 are the magnitude
ACC_W, 8, accumulator/result width: bit ACC_W-1 is the sign, bits ACC_W-2:0 are the magnitude; ACC_W > N required
CNT_W, 8, width of the accepted-word counter

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data and in_last are valid
in_ready  output  1  block can accept a word this cycle
in_data  input  N  sign-magnitude operand
in_last  input  1  marks the final word of a packet
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_data  output  ACC_W  sign-magnitude packet sum
out_count  output  CNT_W  number of words in the packet
out_ovf  output  1  sticky saturation flag for the packet

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; acc, out_data, out_count, out_ovf = 0; out_valid = 0. in_ready = 0 while rst_n = 0.
- Accept: a word is accepted on a rising edge where in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD. in_ready is a combinational function of state.
- Operand normalisation: the input magnitude is zero-extended to ACC_W-1 bits. An input of -0 (sign 1, magnitude 0) is treated as +0.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, on accept:
  - acc = normalised input; count = 1; ovf = 0.
  - If in_last, go to HOLD; else go to ACCUM.
- ACCUM, on accept:
  - acc = acc (+) input, where (+) is the sign-magnitude add defined below.
  - count = count + 1, saturating at 2^CNT_W - 1.
  - If in_last, go to HOLD. With no accept, hold all state.
- Sign-magnitude add:
  - Equal signs: magnitudes are added at ACC_W bits; the sign is kept.
  - Differing signs: the smaller magnitude is subtracted from the larger; the result takes the sign of the larger magnitude.
  - Equal magnitudes with differing signs give +0.
  - A result magnitude of 0 always has sign 0. The block never outputs -0.
- Saturation: if the magnitude sum exceeds 2^(ACC_W-1) - 1:
  - magnitude = 2^(ACC_W-1) - 1, with the operand sign;
  - ovf = 1, sticky until the next packet starts.
  - Later words add to the saturated value normally; for example, a subtraction can bring the value back in range, but ovf stays 1.
- HOLD:
  - out_valid = 1; out_data = acc, out_count = count, out_ovf = ovf, all stable while out_ready = 0.
  - On out_valid && out_ready: go to IDLE and clear out_valid the next cycle. out_data, out_count and out_ovf keep their last values until the next HOLD.
- Latency: out_valid rises on the edge after the edge that accepted the in_last word.
- Throughput: one word per cycle inside a packet. HOLD costs at least 1 cycle between packets; there is no input bypass in HOLD.
- Single-word packet: the word accepted in IDLE with in_last = 1 goes directly to HOLD.
- Reset mid-packet or in HOLD: all state clears asynchronously. A partial packet is discarded and no output is produced for it.
- in_last without in_valid is ignored. in_data is not sampled unless a word is accepted.

Test Plan:
1. N=4, ACC_W=8. Packet +3 (0011), -5 (1101), +2 (0010, last) -> running acc 0x03, 0x82, 0x00; result out_data=0x00 (+0, not 0x80), out_count=3, out_ovf=0, out_valid exactly 1 cycle after the last accept.
2. Packet of 19 words of +7 (0111), last on the 19th -> acc reaches 126 after 18 words, then saturates; out_data=0x7F, out_count=19, out_ovf=1. A follow-up packet {+1 last} -> out_data=0x01, out_ovf=0.
3. Packet -7 (1111), -7 (1111, last) -> out_data=0x8E (-14), out_count=2. Single-word packet -0 (1000, last) -> out_data=0x00, out_count=1.
4. Backpressure: result in HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, no words accepted, out_data/out_count/out_ovf stable. Raise out_ready -> IDLE next cycle, in_ready=1, next word accepted.
5. Reset mid-packet: accept +4, +4, then pull rst_n low asynchronously (not clock-aligned) -> out_valid=0 and in_ready=0 immediately, all state 0. After release, packet {+1 last} -> out_data=0x01, out_count=1.
6. Gapped input: +2, in_valid low for 3 cycles, +5 (last) -> out_data=0x07, out_count=2, no state change during the gap.
